// File: rtl/sle_bank_seq.sv
// Command sequencer for a bank of flop-mode SLE registers sharing EN/SLn/SD/ALn/ADn/LAT.
// Commands queue in a small FIFO; each runs a settle phase, a strobe phase and a one-cycle DONE.
module sle_bank_seq #(
   parameter int AW        = 1,
   parameter int SETUP_CYC = 1,
   parameter bit INIT_VAL  = 1'b0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CMD_VALID,
   output logic       CMD_READY,
   input  logic [1:0] CMD_OP,
   input  logic [3:0] CMD_ARG,
   output logic       SLE_EN,
   output logic       SLE_SLN,
   output logic       SLE_SD,
   output logic       SLE_ALN,
   output logic       SLE_ADN,
   output logic       SLE_LAT,
   output logic       BUSY,
   output logic       DONE,
   output logic [7:0] DONE_CNT
);
   localparam int         DEPTH      = 2 ** AW;
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
   localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
   localparam logic [1:0] OP_CLEAR   = 2'b01;
   localparam logic [1:0] OP_SET     = 2'b10;
   localparam logic [1:0] OP_HOLD    = 2'b11;

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_DONE} state_t;

   logic [5:0]    fifo_mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   state_t        state_q, state_d;
   logic [1:0]    op_q, op_d;
   logic [3:0]    arg_q, arg_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          en_q, en_d, sln_q, sln_d, sd_q, sd_d, done_q, done_d;
   logic [7:0]    done_cnt_q, done_cnt_d;
   logic          push, pop;
   logic [5:0]    head;

   assign CMD_READY = ~RST & (count_q != FULL_COUNT);
   assign push      = CMD_VALID & CMD_READY;
   assign pop       = (state_q == ST_IDLE) && (count_q != '0);
   assign head      = fifo_mem[rd_ptr_q];

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      arg_d      = arg_q;
      cnt_d      = cnt_q;
      done_cnt_d = done_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               op_d  = head[5:4];
               arg_d = head[3:0];
               if (SETUP_CYC > 0) begin
                  state_d = ST_SETUP;
                  cnt_d   = SETUP_LAST;
               end else begin
                  state_d = ST_STROBE;
                  cnt_d   = head[3:0];
               end
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               state_d = ST_STROBE;
               cnt_d   = arg_q;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_STROBE: begin
            if (cnt_q == '0) state_d = ST_DONE;
            else cnt_d = cnt_q - 1'b1;
         end
         ST_DONE: begin
            state_d    = ST_IDLE;
            done_cnt_d = done_cnt_q + 1'b1;
         end
      endcase

      // Outputs are registered from the next state so the SLE pins never glitch.
      en_d   = (state_d == ST_STROBE) && (op_d != OP_HOLD);
      sln_d  = 1'b1;
      sd_d   = 1'b0;
      done_d = (state_d == ST_DONE);
      if (state_d == ST_SETUP || state_d == ST_STROBE) begin
         case (op_d)
            OP_CLEAR: sln_d = 1'b0;
            OP_SET: begin
               sln_d = 1'b0;
               sd_d  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (push) fifo_mem[wr_ptr_q] <= {CMD_OP, CMD_ARG};
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= ST_IDLE;
         op_q       <= '0;
         arg_q      <= '0;
         cnt_q      <= '0;
         en_q       <= 1'b0;
         sln_q      <= 1'b1;
         sd_q       <= 1'b0;
         done_q     <= 1'b0;
         done_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         op_q       <= op_d;
         arg_q      <= arg_d;
         cnt_q      <= cnt_d;
         en_q       <= en_d;
         sln_q      <= sln_d;
         sd_q       <= sd_d;
         done_q     <= done_d;
         done_cnt_q <= done_cnt_d;
      end
   end

   // Async-load is held active for the whole reset so the bank powers up at INIT_VAL.
   assign SLE_ALN  = ~RST;
   assign SLE_ADN  = ~INIT_VAL;
   assign SLE_LAT  = 1'b0;
   assign SLE_EN   = en_q;
   assign SLE_SLN  = sln_q;
   assign SLE_SD   = sd_q;
   assign DONE     = done_q;
   assign DONE_CNT = done_cnt_q;
   assign BUSY     = (state_q != ST_IDLE) || (count_q != '0);
endmodule

// File: tb/tb_sle_bank_seq.sv
// Bench for sle_bank_seq: directed scenarios plus random traffic, every cycle checked
// against a schedule model (per-command start cycle + phase arithmetic, command queue).
`timescale 1ns/1ps
module tb_sle_bank_seq;
   localparam int AW    = 1;
   localparam int DEPTH = 2 ** AW;
   localparam int SC    = 1;
   localparam bit INIT  = 1'b1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'd0;
   logic [3:0] cmd_arg = 4'd0;
   logic       cmd_ready, sle_en, sle_sln, sle_sd, sle_aln, sle_adn, sle_lat, busy, done;
   logic [7:0] done_cnt;

   always #5 clk = ~clk;

   sle_bank_seq #(.AW(AW), .SETUP_CYC(SC), .INIT_VAL(INIT)) dut (
      .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
      .CMD_OP(cmd_op), .CMD_ARG(cmd_arg), .SLE_EN(sle_en), .SLE_SLN(sle_sln),
      .SLE_SD(sle_sd), .SLE_ALN(sle_aln), .SLE_ADN(sle_adn), .SLE_LAT(sle_lat),
      .BUSY(busy), .DONE(done), .DONE_CNT(done_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: queue of accepted commands and the schedule of the running one.
   logic [5:0] q[$];
   bit         act = 1'b0;
   int         act_s, act_end;
   logic [1:0] act_op;
   logic [7:0] m_cnt = 8'd0;
   bit         m_accepted;
   int         done_seen = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // 0 idle, 1 setup, 2 strobe, 3 done
   function automatic int phase_of(input int c);
      if (!act || c < act_s || c > act_end) return 0;
      if (c < act_s + SC) return 1;
      if (c < act_end) return 2;
      return 3;
   endfunction

   task automatic model_edge();
      int  pre;
      bit  idle_pre, ready_pre;
      logic [5:0] c;
      cyc++;
      m_accepted = 1'b0;
      if (rst) begin
         q.delete();
         act   = 1'b0;
         m_cnt = 8'd0;
      end else begin
         pre       = cyc - 1;
         idle_pre  = !act || pre > act_end;
         ready_pre = q.size() != DEPTH;
         if (act && pre == act_end) m_cnt++;
         if (idle_pre && q.size() != 0) begin
            c       = q.pop_front();
            act     = 1'b1;
            act_s   = cyc;
            act_op  = c[5:4];
            act_end = cyc + SC + int'(c[3:0]) + 1;
         end
         if (cmd_valid && ready_pre) begin
            q.push_back({cmd_op, cmd_arg});
            m_accepted = 1'b1;
            $display("cycle %0d: accepted op=%0d arg=%0d queued=%0d done_cnt=%0d",
                     cyc, cmd_op, cmd_arg, q.size(), m_cnt);
         end
      end
   endtask

   task automatic check_outputs();
      int ph;
      bit strobe_or_setup;
      ph = phase_of(cyc);
      strobe_or_setup = (ph == 1 || ph == 2);
      check_eq("sle_en",   sle_en,   (ph == 2) && act_op != 2'd3);
      check_eq("sle_sln",  sle_sln,  !(strobe_or_setup && (act_op == 2'd1 || act_op == 2'd2)));
      check_eq("sle_sd",   sle_sd,   strobe_or_setup && act_op == 2'd2);
      check_eq("done",     done,     ph == 3);
      check_eq("busy",     busy,     ph != 0 || q.size() != 0);
      check_eq("cmd_ready", cmd_ready, !rst && q.size() != DEPTH);
      check_eq("done_cnt", done_cnt, m_cnt);
      check_eq("sle_aln",  sle_aln,  !rst);
      check_eq("sle_lat",  sle_lat,  1'b0);
      if (rst) check_eq("sle_adn", sle_adn, !INIT);
      if (done === 1'b1) done_seen++;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic push_cmd(input logic [1:0] op, input logic [3:0] arg);
      int budget = 200;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      do begin
         cycle();
         budget--;
      end while (!m_accepted && budget > 0);
      check_eq("push_accept", m_accepted, 1'b1);
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int budget = 2000;
      cmd_valid = 1'b0;
      while ((phase_of(cyc) != 0 || q.size() != 0) && budget > 0) begin
         cycle();
         budget--;
      end
      check_eq("drain_busy", busy, 1'b0);
   endtask

   initial begin
      int seen0, accepts;
      logic [7:0] cnt0;

      // Reset held for two cycles, then released.
      rst = 1'b1;
      repeat (2) cycle();
      rst = 1'b0;
      cycle();
      check_eq("post_reset_aln", sle_aln, 1'b1);
      check_eq("post_reset_cnt", done_cnt, 8'd0);

      // Reset in the middle of a LOAD strobe with one command queued.
      seen0 = done_seen;
      push_cmd(2'd0, 4'd7);
      push_cmd(2'd1, 4'd0);
      check_eq("mid_queued", q.size(), 1);
      repeat (4) cycle();
      check_eq("mid_in_strobe", sle_en, 1'b1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check_eq("mid_rst_en", sle_en, 1'b0);
      check_eq("mid_rst_busy", busy, 1'b0);
      repeat (20) cycle();
      check_eq("mid_no_done", done_seen - seen0, 0);
      check_eq("mid_cnt", done_cnt, 8'd0);

      // Single LOAD ARG=2, then CLEAR and SET back to back.
      push_cmd(2'd0, 4'd2);
      drain();
      check_eq("load_cnt", done_cnt, 8'd1);
      push_cmd(2'd1, 4'd0);
      push_cmd(2'd2, 4'd0);
      drain();
      check_eq("clr_set_cnt", done_cnt, 8'd3);

      // FIFO full: long HOLD running, offer commands continuously.
      push_cmd(2'd3, 4'd15);
      accepts    = 0;
      cmd_valid  = 1'b1;
      cmd_op     = 2'd0;
      cmd_arg    = 4'd0;
      repeat (8) begin
         cycle();
         if (m_accepted) accepts++;
      end
      cmd_valid = 1'b0;
      check_eq("full_accepts", accepts, 2);
      check_eq("full_ready", cmd_ready, 1'b0);
      drain();

      // 256 CLEARs wrap DONE_CNT back to its starting value.
      cnt0  = done_cnt;
      seen0 = done_seen;
      repeat (256) push_cmd(2'd1, 4'd0);
      drain();
      check_eq("wrap_pulses", done_seen - seen0, 256);
      check_eq("wrap_cnt", done_cnt, cnt0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(399) == 0);
         cmd_valid = $urandom_range(1);
         cmd_op    = 2'($urandom_range(3));
         cmd_arg   = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(3));
         cycle();
      end
      rst = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
